// File: rtl/mux3_bus_arbiter.sv
// mux3_bus_arbiter
//   Arbitrates three requesters (A = ALU result, B = memory read data,
//   C = PC+2 link) onto one WIDTH-bit bus. The winner's data is captured in a
//   single-entry output register that a consumer drains with VALID/RDY.
//
//   Build option: define MUX3ARB_FIXED_PRI_EN for fixed priority A > B > C;
//   when it is undefined the arbiter is round-robin.
//
// Ports
//   CLK    in   clock, rising edge
//   Reset  in   synchronous active-high reset
//   EN     in   grant enable (draining continues while low)
//   REQ    in   [2:0] level requests, bit0=A bit1=B bit2=C
//   A,B,C  in   [WIDTH-1:0] source data
//   GNT    out  [2:0] one-hot grant, combinational, accept cycle only
//   S      out  [1:0] select of the source now held in O (0=A 1=B 2=C)
//   O      out  [WIDTH-1:0] registered output data
//   VALID  out  O/S hold an undelivered transfer
//   RDY    in   consumer ready
module mux3_bus_arbiter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             EN,
   input  logic [2:0]       REQ,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   output logic [2:0]       GNT,
   output logic [1:0]       S,
   output logic [WIDTH-1:0] O,
   output logic             VALID,
   input  logic             RDY
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t     state;
   logic [1:0] win;
   logic       acc;
   logic [WIDTH-1:0] win_data;

`ifdef MUX3ARB_FIXED_PRI_EN
   // Lowest set REQ bit wins.
   always_comb begin
      win = 2'd0;
      if (REQ[0])
         win = 2'd0;
      else if (REQ[1])
         win = 2'd1;
      else if (REQ[2])
         win = 2'd2;
   end
`else
   // Next source to be considered first; only ever 0, 1 or 2.
   logic [1:0] ptr;

   // Search order starts at ptr and wraps modulo 3.
   always_comb begin
      win = 2'd0;
      case (ptr)
         2'd1: begin
            if (REQ[1])      win = 2'd1;
            else if (REQ[2]) win = 2'd2;
            else if (REQ[0]) win = 2'd0;
         end
         2'd2: begin
            if (REQ[2])      win = 2'd2;
            else if (REQ[0]) win = 2'd0;
            else if (REQ[1]) win = 2'd1;
         end
         default: begin
            if (REQ[0])      win = 2'd0;
            else if (REQ[1]) win = 2'd1;
            else if (REQ[2]) win = 2'd2;
         end
      endcase
   end
`endif

   // A new transfer is accepted when the register is free or being drained
   // in this same cycle; Reset suppresses any grant.
   assign acc = ~Reset & EN & (|REQ) & ((state == EMPTY) | RDY);

   always_comb begin
      GNT = '0;
      if (acc)
         GNT = 3'b001 << win;
   end

   always_comb begin
      case (win)
         2'd1:    win_data = B;
         2'd2:    win_data = C;
         default: win_data = A;
      endcase
   end

   assign VALID = (state == FULL);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= EMPTY;
         O     <= '0;
         S     <= '0;
`ifndef MUX3ARB_FIXED_PRI_EN
         ptr   <= '0;
`endif
      end else if (acc) begin
         state <= FULL;
         O     <= win_data;
         S     <= win;
`ifndef MUX3ARB_FIXED_PRI_EN
         ptr   <= (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
      end else if ((state == FULL) && RDY) begin
         // Drained with nothing to refill: O/S keep their last values.
         state <= EMPTY;
      end
   end

endmodule
